// File: rtl/axi_lite_dram_slave.sv
// ---------------------------------------------------------------------------
// AxiLiteDramSlave
//
// AXI4-Lite responder standing in for the off-chip DRAM behind the farm
// bridge. It serves one transaction at a time out of an internal
// word-addressed memory. Read data and write responses are returned after a
// configurable number of idle cycles.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   AR_VALID/ADDR/READY read address channel
//   R_VALID/DATA/RESP   read data channel, R_READY from master
//   AW_VALID/ADDR/READY write address channel
//   W_VALID/DATA/READY  write data channel
//   B_VALID/RESP        write response channel, B_READY from master
//   busy                high whenever the controller is not idle
//
// Decode: the word index is addr[9:2]. An access is OKAY only when
// addr[16:10] matches BASE, the address is word aligned, and the index is
// below DEPTH. Any other access gets SLVERR. A failed read returns zero, and
// a failed write leaves memory untouched.
// ---------------------------------------------------------------------------
module axi_lite_dram_slave #(
   parameter int                ADDR_W = 17,
   parameter int                DATA_W = 32,
   parameter int                DEPTH  = 256,
   parameter logic [ADDR_W-1:0] BASE   = 17'h10000,
   parameter int                R_LAT  = 2,
   parameter int                B_LAT  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              AR_VALID,
   input  logic [ADDR_W-1:0] AR_ADDR,
   output logic              AR_READY,
   output logic              R_VALID,
   output logic [DATA_W-1:0] R_DATA,
   output logic [1:0]        R_RESP,
   input  logic              R_READY,
   input  logic              AW_VALID,
   input  logic [ADDR_W-1:0] AW_ADDR,
   output logic              AW_READY,
   input  logic              W_VALID,
   input  logic [DATA_W-1:0] W_DATA,
   output logic              W_READY,
   output logic              B_VALID,
   output logic [1:0]        B_RESP,
   input  logic              B_READY,
   output logic              busy
);

   typedef enum logic [2:0] {
      IDLE,
      AR_ACK,
      RD_WAIT,
      RD_RESP,
      AW_ACK,
      WR_DATA,
      WR_WAIT,
      WR_RESP
   } state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   state_t            state_q;
   logic [ADDR_W-1:0] addr_q;
   logic [3:0]        cnt_q;
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic              arReady_q;
   logic              rValid_q;
   logic [DATA_W-1:0] rData_q;
   logic [1:0]        rResp_q;
   logic              awReady_q;
   logic              wReady_q;
   logic              bValid_q;
   logic [1:0]        bResp_q;
   logic              busy_q;

   // With zero read latency the response is loaded in the same edge that
   // captures the address, so the read path looks at AR_ADDR directly during
   // AR_ACK. Otherwise it uses the captured address.
   logic [ADDR_W-1:0] rdAddr_d;
   logic [7:0]        rdIdx;
   logic [7:0]        wrIdx;
   logic              rdIdxOk;
   logic              wrIdxOk;
   logic              rdOk;
   logic              wrOk;
   logic [DATA_W-1:0] rdWord;

   assign rdAddr_d = (state_q == AR_ACK) ? AR_ADDR : addr_q;
   assign rdIdx    = rdAddr_d[9:2];
   assign wrIdx    = addr_q[9:2];

   // An 8-bit index always fits a full 256-word memory, so the range check
   // is only needed for smaller depths.
   generate
      if (DEPTH >= 256) begin : gFullDepth
         assign rdIdxOk = 1'b1;
         assign wrIdxOk = 1'b1;
      end else begin : gPartialDepth
         assign rdIdxOk = (32'(rdIdx) < DEPTH);
         assign wrIdxOk = (32'(wrIdx) < DEPTH);
      end
   endgenerate

   assign rdOk   = (rdAddr_d[16:10] == BASE[16:10]) && (rdAddr_d[1:0] == 2'b00) && rdIdxOk;
   assign wrOk   = (addr_q[16:10] == BASE[16:10]) && (addr_q[1:0] == 2'b00) && wrIdxOk;
   assign rdWord = rdOk ? mem_q[rdIdx] : '0;

   // The controller, its registered channel outputs and the memory all live
   // in one clocked block. Reset abandons any transaction in flight and wipes
   // the memory.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         cnt_q     <= '0;
         arReady_q <= 1'b0;
         rValid_q  <= 1'b0;
         rData_q   <= '0;
         rResp_q   <= '0;
         awReady_q <= 1'b0;
         wReady_q  <= 1'b0;
         bValid_q  <= 1'b0;
         bResp_q   <= '0;
         busy_q    <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (AR_VALID) begin
                  state_q   <= AR_ACK;
                  arReady_q <= 1'b1;
                  busy_q    <= 1'b1;
               end else if (AW_VALID) begin
                  state_q   <= AW_ACK;
                  awReady_q <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            AR_ACK: begin
               arReady_q <= 1'b0;
               addr_q    <= AR_ADDR;
               if (R_LAT == 0) begin
                  state_q  <= RD_RESP;
                  rValid_q <= 1'b1;
                  rData_q  <= rdWord;
                  rResp_q  <= rdOk ? RESP_OKAY : RESP_SLVERR;
               end else begin
                  state_q <= RD_WAIT;
                  cnt_q   <= 4'(R_LAT);
               end
            end
            RD_WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q  <= RD_RESP;
                  rValid_q <= 1'b1;
                  rData_q  <= rdWord;
                  rResp_q  <= rdOk ? RESP_OKAY : RESP_SLVERR;
               end
            end
            RD_RESP: begin
               if (R_READY) begin
                  state_q  <= IDLE;
                  rValid_q <= 1'b0;
                  rData_q  <= '0;
                  rResp_q  <= '0;
                  busy_q   <= 1'b0;
               end
            end
            AW_ACK: begin
               awReady_q <= 1'b0;
               addr_q    <= AW_ADDR;
               wReady_q  <= 1'b1;
               state_q   <= WR_DATA;
            end
            WR_DATA: begin
               if (W_VALID) begin
                  wReady_q <= 1'b0;
                  if (wrOk) begin
                     mem_q[wrIdx] <= W_DATA;
                  end
                  if (B_LAT == 0) begin
                     state_q  <= WR_RESP;
                     bValid_q <= 1'b1;
                     bResp_q  <= wrOk ? RESP_OKAY : RESP_SLVERR;
                  end else begin
                     state_q <= WR_WAIT;
                     cnt_q   <= 4'(B_LAT);
                  end
               end
            end
            WR_WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q  <= WR_RESP;
                  bValid_q <= 1'b1;
                  bResp_q  <= wrOk ? RESP_OKAY : RESP_SLVERR;
               end
            end
            WR_RESP: begin
               if (B_READY) begin
                  state_q  <= IDLE;
                  bValid_q <= 1'b0;
                  bResp_q  <= '0;
                  busy_q   <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign AR_READY = arReady_q;
   assign R_VALID  = rValid_q;
   assign R_DATA   = rData_q;
   assign R_RESP   = rResp_q;
   assign AW_READY = awReady_q;
   assign W_READY  = wReady_q;
   assign B_VALID  = bValid_q;
   assign B_RESP   = bResp_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_axi_lite_dram_slave.sv
// ---------------------------------------------------------------------------
// Testbench for axi_lite_dram_slave.
//
// Directed transactions are driven just after the rising edge. A
// transaction-level model runs on the falling edge. It keeps a plain memory
// array and a list of pending responses with their due cycles. Every cycle it
// checks the channel outputs against the model. The directed tasks also pin a
// few literal values such as latencies, data words and response codes.
// ---------------------------------------------------------------------------
module tb_axi_lite_dram_slave;

   localparam int          R_LAT     = 2;
   localparam int          B_LAT     = 1;
   localparam logic [16:0] BASE_ADDR = 17'h10000;

   logic        clk;
   logic        rst;
   logic        AR_VALID;
   logic [16:0] AR_ADDR;
   logic        AR_READY;
   logic        R_VALID;
   logic [31:0] R_DATA;
   logic [1:0]  R_RESP;
   logic        R_READY;
   logic        AW_VALID;
   logic [16:0] AW_ADDR;
   logic        AW_READY;
   logic        W_VALID;
   logic [31:0] W_DATA;
   logic        W_READY;
   logic        B_VALID;
   logic [1:0]  B_RESP;
   logic        B_READY;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int rdT0   = 0;
   bit rstAtEdge;
   bit outOfReset;

   // Transaction-level model state
   logic [31:0] modelMem [256];
   bit          rdPending;
   bit          rdSeen;
   int          rdExpCyc;
   logic [31:0] rdExpData;
   logic [1:0]  rdExpResp;
   bit          awPending;
   logic [16:0] awAddr;
   bit          bPending;
   bit          bSeen;
   int          bExpCyc;
   logic [1:0]  bExpResp;

   axi_lite_dram_slave #(
      .ADDR_W(17),
      .DATA_W(32),
      .DEPTH (256),
      .BASE  (BASE_ADDR),
      .R_LAT (R_LAT),
      .B_LAT (B_LAT)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .AR_VALID(AR_VALID),
      .AR_ADDR (AR_ADDR),
      .AR_READY(AR_READY),
      .R_VALID (R_VALID),
      .R_DATA  (R_DATA),
      .R_RESP  (R_RESP),
      .R_READY (R_READY),
      .AW_VALID(AW_VALID),
      .AW_ADDR (AW_ADDR),
      .AW_READY(AW_READY),
      .W_VALID (W_VALID),
      .W_DATA  (W_DATA),
      .W_READY (W_READY),
      .B_VALID (B_VALID),
      .B_RESP  (B_RESP),
      .B_READY (B_READY),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter. It also notes whether the DUT saw reset on this edge.
   always @(posedge clk) begin
      cyc       <= cyc + 1;
      rstAtEdge <= rst;
      if (rst) outOfReset <= 1'b1;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   function automatic bit addrOk(input logic [16:0] a);
      return (a[16:10] == BASE_ADDR[16:10]) && (a[1:0] == 2'b00);
   endfunction

   // Transaction-level reference model, checked every falling edge
   always @(negedge clk) begin
      if (rstAtEdge) begin
         checkOutput("rst_ar_ready", 64'(AR_READY), 64'd0);
         checkOutput("rst_aw_ready", 64'(AW_READY), 64'd0);
         checkOutput("rst_w_ready", 64'(W_READY), 64'd0);
         checkOutput("rst_r_valid", 64'(R_VALID), 64'd0);
         checkOutput("rst_r_data", 64'(R_DATA), 64'd0);
         checkOutput("rst_r_resp", 64'(R_RESP), 64'd0);
         checkOutput("rst_b_valid", 64'(B_VALID), 64'd0);
         checkOutput("rst_b_resp", 64'(B_RESP), 64'd0);
         checkOutput("rst_busy", 64'(busy), 64'd0);
         rdPending = 1'b0;
         rdSeen    = 1'b0;
         awPending = 1'b0;
         bPending  = 1'b0;
         bSeen     = 1'b0;
         for (int i = 0; i < 256; i++) modelMem[i] = '0;
      end else if (outOfReset) begin
         checkOutput("ar_aw_exclusive", 64'(AR_READY & AW_READY), 64'd0);
         if (!awPending) checkOutput("w_ready_idle", 64'(W_READY), 64'd0);
         if (AR_READY) begin
            checkOutput("ar_one_outstanding", 64'(rdPending | awPending | bPending), 64'd0);
            rdPending = 1'b1;
            rdSeen    = 1'b0;
            rdExpCyc  = cyc + 1 + R_LAT;
            if (addrOk(AR_ADDR)) begin
               rdExpData = modelMem[AR_ADDR[9:2]];
               rdExpResp = 2'b00;
            end else begin
               rdExpData = 32'h0;
               rdExpResp = 2'b10;
            end
         end
         if (AW_READY) begin
            checkOutput("aw_one_outstanding", 64'(rdPending | awPending | bPending), 64'd0);
            awPending = 1'b1;
            awAddr    = AW_ADDR;
         end
         if (W_READY && W_VALID && awPending) begin
            if (addrOk(awAddr)) modelMem[awAddr[9:2]] = W_DATA;
            bExpResp  = addrOk(awAddr) ? 2'b00 : 2'b10;
            bExpCyc   = cyc + 1 + B_LAT;
            bPending  = 1'b1;
            bSeen     = 1'b0;
            awPending = 1'b0;
         end
         checkOutput("busy", 64'(busy), 64'(rdPending | awPending | bPending));
         if (rdPending && R_VALID) begin
            if (!rdSeen) checkOutput("r_latency", 64'(cyc), 64'(rdExpCyc));
            rdSeen = 1'b1;
            checkOutput("r_data", 64'(R_DATA), 64'(rdExpData));
            checkOutput("r_resp", 64'(R_RESP), 64'(rdExpResp));
            if (R_READY) rdPending = 1'b0;
         end else if (!rdPending) begin
            checkOutput("r_valid_idle", 64'(R_VALID), 64'd0);
         end else if (cyc >= rdExpCyc) begin
            checkOutput("r_valid_due", 64'(R_VALID), 64'd1);
         end
         if (bPending && B_VALID) begin
            if (!bSeen) checkOutput("b_latency", 64'(cyc), 64'(bExpCyc));
            bSeen = 1'b1;
            checkOutput("b_resp", 64'(B_RESP), 64'(bExpResp));
            if (B_READY) bPending = 1'b0;
         end else if (!bPending) begin
            checkOutput("b_valid_idle", 64'(B_VALID), 64'd0);
         end else if (cyc >= bExpCyc) begin
            checkOutput("b_valid_due", 64'(B_VALID), 64'd1);
         end
      end
   end

   task automatic readStart(input logic [16:0] a);
      @(posedge clk); #1;
      AR_VALID = 1'b1;
      AR_ADDR  = a;
      rdT0     = cyc;
   endtask

   // Completes a read that readStart opened. "hold" is the number of cycles
   // R_READY stays low once R_VALID is up.
   task automatic readFinish(input int hold, output logic [31:0] d, output logic [1:0] r,
                             output int arC, output int rvC);
      int n;
      R_READY = (hold == 0);
      n = 0;
      do begin @(negedge clk); n++; end while (!AR_READY && n < 20);
      if (!AR_READY) checkOutput("ar_ready_wait", 64'(AR_READY), 64'd1);
      arC = cyc - rdT0;
      @(posedge clk); #1;
      AR_VALID = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!R_VALID && n < 40);
      if (!R_VALID) checkOutput("r_valid_wait", 64'(R_VALID), 64'd1);
      rvC = cyc - rdT0;
      d   = R_DATA;
      r   = R_RESP;
      for (int i = 0; i < hold; i++) begin
         checkOutput("hold_r_valid", 64'(R_VALID), 64'd1);
         checkOutput("hold_busy", 64'(busy), 64'd1);
         checkOutput("hold_ar_ready", 64'(AR_READY), 64'd0);
         @(negedge clk);
      end
      if (hold > 0) begin
         @(posedge clk); #1;
         R_READY = 1'b1;
      end
      @(posedge clk); #1;
      R_READY = 1'b0;
   endtask

   task automatic readFull(input logic [16:0] a, output logic [31:0] d, output logic [1:0] r);
      int arC, rvC;
      readStart(a);
      readFinish(0, d, r, arC, rvC);
   endtask

   task automatic writeTxn(input logic [16:0] a, input logic [31:0] data,
                           output logic [1:0] resp, output int bLat);
      int n, wC;
      @(posedge clk); #1;
      AW_VALID = 1'b1;
      AW_ADDR  = a;
      n = 0;
      do begin @(negedge clk); n++; end while (!AW_READY && n < 40);
      if (!AW_READY) checkOutput("aw_ready_wait", 64'(AW_READY), 64'd1);
      @(posedge clk); #1;
      AW_VALID = 1'b0;
      W_VALID  = 1'b1;
      W_DATA   = data;
      B_READY  = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!W_READY && n < 20);
      if (!W_READY) checkOutput("w_ready_wait", 64'(W_READY), 64'd1);
      wC = cyc;
      @(posedge clk); #1;
      W_VALID = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!B_VALID && n < 40);
      if (!B_VALID) checkOutput("b_valid_wait", 64'(B_VALID), 64'd1);
      bLat = cyc - wC;
      resp = B_RESP;
      @(posedge clk); #1;
      B_READY = 1'b0;
   endtask

   task automatic applyStimulus();
      logic [31:0] d;
      logic [1:0]  r;
      int          arC, rvC, bLat, n;

      // First read after reset: latency pinned and memory zero
      readStart(17'h10004);
      readFinish(0, d, r, arC, rvC);
      checkOutput("t1_ar_cycle", 64'(arC), 64'd1);
      checkOutput("t1_rvalid_cycle", 64'(rvC), 64'd4);
      checkOutput("t1_data", 64'(d), 64'h0);
      checkOutput("t1_resp", 64'(r), 64'd0);

      // Write, then read it back
      writeTxn(17'h10010, 32'hDEADBEEF, r, bLat);
      checkOutput("t2_b_resp", 64'(r), 64'd0);
      checkOutput("t2_b_latency", 64'(bLat), 64'd2);
      readFull(17'h10010, d, r);
      checkOutput("t2_data", 64'(d), 64'hDEADBEEF);
      checkOutput("t2_resp", 64'(r), 64'd0);

      // Read and write presented together: the read is served first
      readStart(17'h10010);
      AW_VALID = 1'b1;
      AW_ADDR  = 17'h10010;
      readFinish(0, d, r, arC, rvC);
      checkOutput("t3_read_old", 64'(d), 64'hDEADBEEF);
      writeTxn(17'h10010, 32'h12345678, r, bLat);
      checkOutput("t3_b_resp", 64'(r), 64'd0);
      readFull(17'h10010, d, r);
      checkOutput("t3_read_new", 64'(d), 64'h12345678);

      // Back-pressure on the read data channel
      readStart(17'h10010);
      readFinish(5, d, r, arC, rvC);
      checkOutput("t4_data", 64'(d), 64'h12345678);
      checkOutput("t4_resp", 64'(r), 64'd0);

      // Accesses outside the window, or misaligned, get SLVERR
      writeTxn(17'h00004, 32'hCAFEF00D, r, bLat);
      checkOutput("t5_b_slverr", 64'(r), 64'd2);
      readFull(17'h10402, d, r);
      checkOutput("t5_r_slverr", 64'(r), 64'd2);
      checkOutput("t5_r_zero", 64'(d), 64'h0);
      readFull(17'h10004, d, r);
      checkOutput("t5_mem_unchanged", 64'(d), 64'h0);
      readFull(17'h10006, d, r);
      checkOutput("t5_misaligned", 64'(r), 64'd2);

      // Several words including the last index of the window
      for (int i = 0; i < 4; i++) begin
         writeTxn(17'h10100 + 17'(4 * i), 32'hA5A50000 + 32'(i), r, bLat);
         checkOutput("t6_b_resp", 64'(r), 64'd0);
      end
      writeTxn(17'h103FC, 32'h0BADCAFE, r, bLat);
      for (int i = 3; i >= 0; i--) begin
         readFull(17'h10100 + 17'(4 * i), d, r);
         checkOutput("t6_data", 64'(d), 64'(32'hA5A50000 + 32'(i)));
      end
      readFull(17'h103FC, d, r);
      checkOutput("t6_last_word", 64'(d), 64'h0BADCAFE);
      checkOutput("t6_last_resp", 64'(r), 64'd0);

      // Reset while waiting for read latency
      readStart(17'h10010);
      R_READY = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!AR_READY && n < 20);
      if (!AR_READY) checkOutput("t7_ar_ready_wait", 64'(AR_READY), 64'd1);
      @(posedge clk); #1;
      AR_VALID = 1'b0;
      rst      = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("t7_busy", 64'(busy), 64'd0);
      checkOutput("t7_r_valid", 64'(R_VALID), 64'd0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("t7_no_r_valid", 64'(R_VALID), 64'd0);
      end
      R_READY = 1'b0;
      readFull(17'h10010, d, r);
      checkOutput("t7_mem_cleared", 64'(d), 64'h0);
      checkOutput("t7_resp", 64'(r), 64'd0);
   endtask

   initial begin
      rst      = 1'b1;
      AR_VALID = 1'b0;
      AR_ADDR  = '0;
      R_READY  = 1'b0;
      AW_VALID = 1'b0;
      AW_ADDR  = '0;
      W_VALID  = 1'b0;
      W_DATA   = '0;
      B_READY  = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_r_valid", 64'(R_VALID), 64'd0);
      applyStimulus();
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
